// File: rtl/rpi_if_pkg.sv
// Shared definitions for the Raspberry Pi serial link (receive side and clock generator side).
// Holds the FSM state encoding and the default word/synchronizer sizes.
package rpi_if_pkg;

    localparam int unsigned RPI_WORD_WIDTH  = 16;
    localparam int unsigned RPI_SYNC_STAGES = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_e;

endpackage

// File: rtl/rpi_serial_rx_if.sv
// Pi-facing serial lines plus the received-word outputs toward the I2S control logic.
interface rpi_serial_rx_if
    import rpi_if_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = RPI_WORD_WIDTH
);
    logic                  rpi_frame;
    logic                  rpi_sclk;
    logic                  rpi_sdata;
    logic [WORD_WIDTH-1:0] word_out;
    logic                  word_valid;
    logic                  frame_error;
    logic                  busy;

    // master: the Pi side plus downstream consumer; slave: the receiver
    modport master (
        output rpi_frame, rpi_sclk, rpi_sdata,
        input  word_out, word_valid, frame_error, busy
    );

    modport slave (
        input  rpi_frame, rpi_sclk, rpi_sdata,
        output word_out, word_valid, frame_error, busy
    );
endinterface

// File: rtl/rpi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous Pi line with a history flop for edge detection.
module rpi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic async_in,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], async_in};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync = chain[SYNC_STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/rpi_serial_rx.sv
// Receives MSB-first words from the Pi, framed by rpi_frame and clocked by rpi_sclk rising edges.
// Each completed word is presented on word_out with a one-cycle word_valid strobe.
module rpi_serial_rx
    import rpi_if_pkg::*;
#(
    parameter int unsigned WORD_WIDTH  = RPI_WORD_WIDTH,
    parameter int unsigned SYNC_STAGES = RPI_SYNC_STAGES
) (
    input  logic           clk_in,
    input  logic           reset,
    rpi_serial_rx_if.slave rx
);

    localparam int unsigned         CNT_W    = $clog2(WORD_WIDTH);
    localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(WORD_WIDTH - 1);

    logic       frame_rise;
    logic       frame_fall;
    logic       sclk_rise;
    logic       sdata_sync;
    logic       frame_sync_unused;
    logic       sclk_sync_unused;
    logic       sclk_fall_unused;
    logic [1:0] sdata_edges_unused;

    rx_state_e             state;
    logic [CNT_W-1:0]      bitcnt;
    logic [WORD_WIDTH-1:0] shreg;
    logic [WORD_WIDTH-1:0] word_q;
    logic                  word_valid_q;
    logic                  frame_error_q;
    logic                  busy_q;
    logic [WORD_WIDTH-1:0] shreg_next;

    // Identical depth on all three lines keeps sdata aligned with the sclk edge
    rpi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_frame (
        .clk_in   (clk_in),
        .reset    (reset),
        .async_in (rx.rpi_frame),
        .sync     (frame_sync_unused),
        .rise     (frame_rise),
        .fall     (frame_fall)
    );

    rpi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_in   (clk_in),
        .reset    (reset),
        .async_in (rx.rpi_sclk),
        .sync     (sclk_sync_unused),
        .rise     (sclk_rise),
        .fall     (sclk_fall_unused)
    );

    rpi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
        .clk_in   (clk_in),
        .reset    (reset),
        .async_in (rx.rpi_sdata),
        .sync     (sdata_sync),
        .rise     (sdata_edges_unused[0]),
        .fall     (sdata_edges_unused[1])
    );

    assign shreg_next = {shreg[WORD_WIDTH-2:0], sdata_sync};

    // Frame fall takes priority over a coincident sclk rise; the error uses the pre-edge count
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            bitcnt        <= '0;
            shreg         <= '0;
            word_q        <= '0;
            word_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            word_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_rise) begin
                        state  <= SHIFT;
                        bitcnt <= '0;
                        shreg  <= '0;
                        busy_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (frame_fall) begin
                        state         <= IDLE;
                        busy_q        <= 1'b0;
                        frame_error_q <= (bitcnt != '0);
                    end else if (sclk_rise) begin
                        shreg <= shreg_next;
                        if (bitcnt == LAST_BIT) begin
                            bitcnt       <= '0;
                            word_q       <= shreg_next;
                            word_valid_q <= 1'b1;
                        end else begin
                            bitcnt <= bitcnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx.word_out    = word_q;
    assign rx.word_valid  = word_valid_q;
    assign rx.frame_error = frame_error_q;
    assign rx.busy        = busy_q;

endmodule

// File: tb/tb_rpi_serial_rx.sv
// Scoreboard bench for rpi_serial_rx: three instances (16/2, 8/3, 24/2) driven by directed frames.
module tb_rpi_serial_rx;
    import rpi_if_pkg::*;

    typedef struct {
        bit          is_err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    int   cyc    = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #10 clk_in = ~clk_in;
    always @(posedge clk_in) cyc++;

    logic frame_d [3];
    logic sclk_d  [3];
    logic sdata_d [3];

    rpi_serial_rx_if #(.WORD_WIDTH(16)) if0 ();
    rpi_serial_rx_if #(.WORD_WIDTH(8))  if1 ();
    rpi_serial_rx_if #(.WORD_WIDTH(24)) if2 ();

    assign if0.rpi_frame = frame_d[0];
    assign if0.rpi_sclk  = sclk_d[0];
    assign if0.rpi_sdata = sdata_d[0];
    assign if1.rpi_frame = frame_d[1];
    assign if1.rpi_sclk  = sclk_d[1];
    assign if1.rpi_sdata = sdata_d[1];
    assign if2.rpi_frame = frame_d[2];
    assign if2.rpi_sclk  = sclk_d[2];
    assign if2.rpi_sdata = sdata_d[2];

    rpi_serial_rx #(.WORD_WIDTH(16), .SYNC_STAGES(2)) dut0 (.clk_in(clk_in), .reset(reset), .rx(if0));
    rpi_serial_rx #(.WORD_WIDTH(8),  .SYNC_STAGES(3)) dut1 (.clk_in(clk_in), .reset(reset), .rx(if1));
    rpi_serial_rx #(.WORD_WIDTH(24), .SYNC_STAGES(2)) dut2 (.clk_in(clk_in), .reset(reset), .rx(if2));

    exp_t        sb0[$];
    exp_t        sb1[$];
    exp_t        sb2[$];
    logic [31:0] last_word [3];
    int          bits_in   [3];

    function automatic int ss_of(int sel);
        return (sel == 1) ? 3 : 2;
    endfunction

    function automatic int ww_of(int sel);
        return (sel == 0) ? 16 : ((sel == 1) ? 8 : 24);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(int sel, exp_t x);
        case (sel)
            0:       sb0.push_back(x);
            1:       sb1.push_back(x);
            default: sb2.push_back(x);
        endcase
    endtask

    // Monitor: pops one expected event whenever a DUT strobes valid or error
    task automatic mon(int sel, logic v, logic e, logic [31:0] w);
        exp_t x;
        bit   have;
        if (!(v || e)) return;
        have = 1'b0;
        case (sel)
            0:       if (sb0.size() > 0) begin x = sb0.pop_front(); have = 1'b1; end
            1:       if (sb1.size() > 0) begin x = sb1.pop_front(); have = 1'b1; end
            default: if (sb2.size() > 0) begin x = sb2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            check($sformatf("dut%0d_unexpected_strobe", sel), {30'd0, e, v}, 32'd0);
            return;
        end
        check($sformatf("dut%0d_strobe_kind", sel), {30'd0, e, v}, x.is_err ? 32'd2 : 32'd1);
        check($sformatf("dut%0d_word_out", sel), w, x.data);
        check($sformatf("dut%0d_latency_cycle", sel), 32'(cyc), 32'(x.cyc));
    endtask

    always @(negedge clk_in) begin
        mon(0, if0.word_valid, if0.frame_error, 32'(if0.word_out));
        mon(1, if1.word_valid, if1.frame_error, 32'(if1.word_out));
        mon(2, if2.word_valid, if2.frame_error, 32'(if2.word_out));
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic frame_up(int sel);
        frame_d[sel] = 1'b1;
        sclk_d[sel]  = 1'b0;
        bits_in[sel] = 0;
        tick(4);
    endtask

    // mode 0: plain bit, 1: last bit of word exp_word, 2: frame falls with this sclk rise
    task automatic send_bit(int sel, logic b, int mode, logic [31:0] exp_word);
        sdata_d[sel] = b;
        sclk_d[sel]  = 1'b0;
        tick(8);
        sclk_d[sel] = 1'b1;
        if (mode == 2) begin
            frame_d[sel] = 1'b0;
            push(sel, exp_t'{is_err: 1'b1, data: last_word[sel], cyc: cyc + ss_of(sel) + 1});
            bits_in[sel] = 0;
        end else if (mode == 1) begin
            push(sel, exp_t'{is_err: 1'b0, data: exp_word, cyc: cyc + ss_of(sel) + 1});
            last_word[sel] = exp_word;
            bits_in[sel]   = 0;
        end else begin
            bits_in[sel]++;
        end
        tick(8);
    endtask

    task automatic send_word(int sel, logic [31:0] w);
        for (int i = ww_of(sel) - 1; i >= 0; i--)
            send_bit(sel, w[i], (i == 0) ? 1 : 0, w);
    endtask

    task automatic frame_down(int sel);
        sclk_d[sel]  = 1'b0;
        frame_d[sel] = 1'b0;
        if (bits_in[sel] != 0)
            push(sel, exp_t'{is_err: 1'b1, data: last_word[sel], cyc: cyc + ss_of(sel) + 1});
        bits_in[sel] = 0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pat;
        for (int s = 0; s < 3; s++) begin
            frame_d[s] = 1'b0; sclk_d[s] = 1'b0; sdata_d[s] = 1'b0;
            last_word[s] = '0; bits_in[s] = 0;
        end
        reset = 1'b1;
        tick(3);
        check("reset_word_out", 32'(if0.word_out), 32'd0);
        check("reset_word_valid", 32'(if0.word_valid), 32'd0);
        check("reset_frame_error", 32'(if0.frame_error), 32'd0);
        check("reset_busy", 32'(if0.busy), 32'd0);
        reset = 1'b0;
        tick(3);

        // Single word with busy rise/fall timing
        frame_d[0] = 1'b1;
        tick(2);
        check("busy_before_rise", 32'(if0.busy), 32'd0);
        tick(1);
        check("busy_after_rise", 32'(if0.busy), 32'd1);
        tick(2);
        send_word(0, 32'h0000_A5C3);
        frame_down(0);
        tick(2);
        check("busy_before_fall", 32'(if0.busy), 32'd1);
        tick(1);
        check("busy_after_fall", 32'(if0.busy), 32'd0);
        tick(4);

        // Back-to-back words in one frame
        frame_up(0);
        send_word(0, 32'h0000_0001);
        send_word(0, 32'h0000_FFFF);
        frame_down(0);
        tick(6);
        check("b2b_final_word", 32'(if0.word_out), 32'h0000_FFFF);

        // Partial frame: 5 bits 1,0,1,1,0
        frame_up(0);
        pat = 16'b10110;
        for (int i = 4; i >= 0; i--) send_bit(0, pat[i], 0, 32'd0);
        frame_down(0);
        tick(6);

        // Frame fall coincides with the 16th sclk rise
        frame_up(0);
        pat = 16'h3C5A;
        for (int i = 15; i >= 1; i--) send_bit(0, pat[i], 0, 32'd0);
        send_bit(0, pat[0], 2, 32'd0);
        sclk_d[0] = 1'b0;
        tick(6);

        // sclk toggling while frame is low
        for (int i = 0; i < 6; i++) begin
            sdata_d[0] = i[0];
            sclk_d[0]  = ~sclk_d[0];
            tick(5);
        end
        check("idle_busy", 32'(if0.busy), 32'd0);
        check("idle_word_hold", 32'(if0.word_out), 32'h0000_FFFF);

        // Reset after 8 bits of a word
        frame_up(0);
        pat = 16'hBEEF;
        for (int i = 15; i >= 8; i--) send_bit(0, pat[i], 0, 32'd0);
        reset = 1'b1;
        #1;
        check("midrst_word_out", 32'(if0.word_out), 32'd0);
        check("midrst_word_valid", 32'(if0.word_valid), 32'd0);
        check("midrst_frame_error", 32'(if0.frame_error), 32'd0);
        check("midrst_busy", 32'(if0.busy), 32'd0);
        frame_d[0] = 1'b0;
        sclk_d[0]  = 1'b0;
        for (int s = 0; s < 3; s++) begin last_word[s] = '0; bits_in[s] = 0; end
        tick(3);
        reset = 1'b0;
        tick(3);
        frame_up(0);
        send_word(0, 32'h0000_1234);
        frame_down(0);
        tick(6);

        // Parameter sweep: 8-bit words with 3 sync stages, then a 24-bit word
        frame_up(1);
        send_word(1, 32'h0000_005A);
        send_word(1, 32'h0000_00C3);
        frame_down(1);
        tick(8);
        frame_up(2);
        send_word(2, 32'h00AB_CDEF);
        frame_down(2);
        tick(10);

        check("sb0_drained", 32'(sb0.size()), 32'd0);
        check("sb1_drained", 32'(sb1.size()), 32'd0);
        check("sb2_drained", 32'(sb2.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rpi_serial_rx.md
# rpi_serial_rx

Receive-side counterpart to the FPGA-generated interrupt/bit clock toward the Raspberry Pi. The Pi drives a frame-enable line, a serial clock and a data line into the FPGA, asynchronous to the FPGA clock. This block synchronizes all three into the `clk_in` domain, detects serial-clock rising edges, and shifts in MSB-first words. It presents each completed word with a one-cycle valid strobe to the downstream I2S control logic.

## Interface
- `WORD_WIDTH`, default 16: bits per received word, legal range 2..32.
- `SYNC_STAGES`, default 2: flip-flop depth of each input synchronizer, legal range 2..4.
- `clk_in`, input, 1: 50 MHz system clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `rpi_frame`, input, 1: Pi frame enable; high means a transfer is in progress. Asynchronous.
- `rpi_sclk`, input, 1: Pi serial clock; data is valid on its rising edge. Asynchronous.
- `rpi_sdata`, input, 1: Pi serial data, MSB first. Asynchronous.
- `word_out`, output, `WORD_WIDTH`: last completed word; holds its value until the next completion.
- `word_valid`, output, 1: one-cycle pulse when `word_out` updates.
- `frame_error`, output, 1: one-cycle pulse when a frame ends with a partial word.
- `busy`, output, 1: high while the FSM is in SHIFT.

## Operation
- All three Pi inputs pass through identical `SYNC_STAGES`-deep synchronizers, so `sdata` stays aligned with `sclk`.
- Edge detection compares each synchronized value with a one-cycle-delayed copy.
  - `sclk_rise` = sync & ~prev.
  - `frame_rise` and `frame_fall` are derived the same way.
- FSM states:
  - **IDLE**: `sclk` edges are ignored. On `frame_rise`: clear the bit counter and shift register, go to SHIFT.
  - **SHIFT**: on `sclk_rise`, shift `{shreg[WORD_WIDTH-2:0], sdata_sync}` and increment `bitcnt`.
    - On the edge that completes bit `WORD_WIDTH-1`: load `word_out` with the full shifted value, pulse `word_valid`, wrap `bitcnt` to 0, stay in SHIFT. Back-to-back words within one frame are supported.
    - On `frame_fall`: go to IDLE. If `bitcnt != 0`, pulse `frame_error` and discard the partial word; `word_out` is unchanged.
- Simultaneous `frame_fall` and `sclk_rise` in the same cycle: the frame fall wins and the bit is not shifted. Error evaluation uses the pre-edge `bitcnt`.
- `frame_rise` while already in SHIFT cannot occur, because a rise requires a preceding fall. No special handling is needed.
- `bitcnt` width is `$clog2(WORD_WIDTH)`. The counter wraps explicitly at `WORD_WIDTH-1` and does not rely on power-of-two overflow.
- No buffering. A downstream consumer must take `word_out` before the next `word_valid`; `word_out` is only overwritten on completion.

## Timing
- Reset values: `word_out`=0, `word_valid`=0, `frame_error`=0, `busy`=0. All synchronizer and edge-history flops reset to 0; FSM resets to IDLE.
- Reset is asynchronous on assertion. Reset mid-frame discards all state with no error pulse.
- After reset release while `rpi_frame` is already high, a `frame_rise` is seen `SYNC_STAGES` cycles later and reception starts. The bench must not treat this as an error.
- Latency: if `rpi_sclk` is first sampled high at `clk_in` edge k, the shift occurs at edge k+`SYNC_STAGES`. For the last bit, `word_valid` and the new `word_out` are visible after that same edge.
- `frame_error` has the same latency relative to the `rpi_frame` falling sample.
- `busy` rises `SYNC_STAGES` edges after `rpi_frame` is first sampled high.
- Input constraints:
  - `rpi_sclk` high and low phases are each ≥ `SYNC_STAGES`+1 `clk_in` periods.
  - `rpi_sdata` is stable for ≥ 2 `clk_in` periods around the `sclk` rise.
  - `rpi_frame` rises ≥ 2 `clk_in` periods before the first `sclk` rise.

## Structure
- Shared package `rpi_if_pkg`:
  - FSM state localparams IDLE=1'b0, SHIFT=1'b1.
  - Default `WORD_WIDTH` and `SYNC_STAGES` constants, shared with the clock-generator side.
- Sub-module `rpi_sync_edge`, parameter `SYNC_STAGES`:
  - Async-reset synchronizer chain plus history flop.
  - Outputs `sync`, `rise`, `fall`.
  - Instantiated three times (frame, sclk, sdata); the sdata instance uses only `sync`.

## Test plan
- **Single word**: frame high; shift 16'hA5C3 with sclk period 16 `clk_in` cycles; frame low → one `word_valid` pulse with `word_out`=16'hA5C3, no `frame_error`, `busy` falls `SYNC_STAGES` cycles after frame low.
- **Back-to-back words**: two words 16'h0001 then 16'hFFFF in one frame → two `word_valid` pulses in order, `word_out` ends at 16'hFFFF, `bitcnt` wraps with no gap.
- **Partial frame**: 5 bits then frame low → `frame_error` pulses once, no `word_valid`, `word_out` holds its prior value.
- **Simultaneous events and idle clocks**: frame low coinciding in synchronized time with the 16th sclk rise → no `word_valid`, `frame_error`=1. `sclk` toggling with frame low → no state change.
- **Reset mid-word**: assert `reset` after 8 bits → all outputs 0 immediately, no pulses. After release, a full 16'h1234 frame is received correctly.
- **Parameter sweep**: `WORD_WIDTH`=8 with `SYNC_STAGES`=3, and `WORD_WIDTH`=24 → correct words, with `word_valid` latency = `SYNC_STAGES` cycles after the last sclk sample.
